// File: rtl/onchip_ram_dual_master_arbiter.sv
// ---------------------------------------------------------------------------
// onchip_ram_dual_master_arbiter
//
// Purpose
//   Shares one single-port on-chip RAM (1-cycle unregistered read) between two
//   Avalon-MM masters: m0 (CPU data) and m1 (audio DMA). At most one access is
//   granted per cycle. The winner's request is driven straight onto the RAM
//   port in the same cycle. Read data goes back to the issuing master one cycle
//   later.
//
// Arbitration
//   Default build: round-robin. A lone requester always wins. When both
//   request, the master that did not win last time gets the grant. After reset
//   last_grant points at m1, so the first contention goes to m0.
//   ONCHIP_ARB_FIXED_PRIO_EN defined: m0 has fixed priority. starve_cnt counts
//   the cycles m1 has waited. When it reaches STARVE_LIMIT, m1 is forced
//   through.
//
// Handshake
//   req_x = mx_read | mx_write. mx_waitrequest = ~grant_x. A transfer is
//   accepted in the cycle where req_x & grant_x. If read and write are both
//   asserted, the transfer is a write. Writes are posted and get no response.
//   A read accepted in cycle N returns mx_readdatavalid=1 with mx_readdata in
//   cycle N+1. mx_readdata holds its last returned value otherwise.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   m0_* / m1_*         Avalon-MM slave ports: address, read, write,
//                       byteenable, writedata, waitrequest, readdata,
//                       readdatavalid
//   ram_*               RAM s1 port: address, byteenable, writedata,
//                       chipselect, write, clken (outputs), readdata (input)
// ---------------------------------------------------------------------------
module onchip_ram_dual_master_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 5120,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic [ADDR_W-1:0]     m0_address,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,

  input  logic [ADDR_W-1:0]     m1_address,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,

  output logic [ADDR_W-1:0]     ram_address,
  output logic [DATA_W/8-1:0]   ram_byteenable,
  output logic [DATA_W-1:0]     ram_writedata,
  output logic                  ram_chipselect,
  output logic                  ram_write,
  output logic                  ram_clken,
  input  logic [DATA_W-1:0]     ram_readdata
);

  localparam int BE_W = DATA_W / 8;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
    $error("STARVE_LIMIT must be in 1..15");
  end

  // -------------------------------------------------------------------------
  // Requests and grants
  // -------------------------------------------------------------------------
  logic req_0;
  logic req_1;
  logic grant_0;
  logic grant_1;

  assign req_0 = m0_read | m0_write;
  assign req_1 = m1_read | m1_write;

`ifdef ONCHIP_ARB_FIXED_PRIO_EN
  localparam logic [3:0] STARVE_LIM_4 = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  always_comb begin
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    if (!reset) begin
      grant_1 = req_1 && (!req_0 || (starve_cnt == STARVE_LIM_4));
      grant_0 = req_0 && !grant_1;
    end
  end

  // Counts cycles in which m1 waits. It clears as soon as m1 is served or
  // stops asking. It saturates so that a long wait cannot wrap the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (req_1 && !grant_1) begin
      if (starve_cnt != 4'hF) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end else begin
      starve_cnt <= 4'd0;
    end
  end
`else
  // 0 = m0 won the last accepted transfer, 1 = m1 won it.
  logic last_grant;

  always_comb begin
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    if (!reset) begin
      grant_0 = req_0 && (!req_1 || last_grant);
      grant_1 = req_1 && (!req_0 || !last_grant);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (grant_0 || grant_1) begin
      last_grant <= grant_1;
    end
  end
`endif

  assign m0_waitrequest = ~grant_0;
  assign m1_waitrequest = ~grant_1;

  // -------------------------------------------------------------------------
  // Winner mux and RAM drive
  // -------------------------------------------------------------------------
  logic              accept;
  logic              acc_write;
  logic              in_range;
  logic [ADDR_W-1:0] win_addr;
  logic [BE_W-1:0]   win_be;
  logic [DATA_W-1:0] win_wdata;

  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wdata_q;

  always_comb begin
    win_addr  = m0_address;
    win_be    = m0_byteenable;
    win_wdata = m0_writedata;
    acc_write = m0_write;
    if (grant_1) begin
      win_addr  = m1_address;
      win_be    = m1_byteenable;
      win_wdata = m1_writedata;
      acc_write = m1_write;
    end
  end

  assign accept   = grant_0 | grant_1;
  assign in_range = (int'(win_addr) < DEPTH);

  // Between accepts, the address, byteenable and writedata lines keep the
  // last transfer's values, so the RAM inputs do not toggle while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= win_addr;
      be_q    <= win_be;
      wdata_q <= win_wdata;
    end
  end

  assign ram_address    = accept ? win_addr  : addr_q;
  assign ram_byteenable = accept ? win_be    : be_q;
  assign ram_writedata  = accept ? win_wdata : wdata_q;

  // Out-of-range transfers are still accepted, but they never reach the RAM.
  assign ram_chipselect = accept & in_range;
  assign ram_write      = accept & in_range & acc_write;
  assign ram_clken      = ~reset;

  // -------------------------------------------------------------------------
  // Read return path
  // -------------------------------------------------------------------------
  logic              rd_pend;
  logic              rd_owner;
  logic              rd_oor;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] rd_hold_0;
  logic [DATA_W-1:0] rd_hold_1;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
      rd_oor   <= 1'b0;
    end else begin
      rd_pend  <= accept & ~acc_write;
      rd_owner <= grant_1;
      rd_oor   <= ~in_range;
    end
  end

  // The return cycle is gated by reset, so a read still in flight when reset
  // arrives is dropped. An out-of-range read returns zero, not stale RAM output.
  assign rd_valid = rd_pend & ~reset;
  assign rd_data  = rd_oor ? '0 : ram_readdata;

  assign m0_readdatavalid = rd_valid & ~rd_owner;
  assign m1_readdatavalid = rd_valid &  rd_owner;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_hold_0 <= '0;
      rd_hold_1 <= '0;
    end else begin
      if (m0_readdatavalid) begin
        rd_hold_0 <= rd_data;
      end
      if (m1_readdatavalid) begin
        rd_hold_1 <= rd_data;
      end
    end
  end

  assign m0_readdata = reset ? '0 : (m0_readdatavalid ? rd_data : rd_hold_0);
  assign m1_readdata = reset ? '0 : (m1_readdatavalid ? rd_data : rd_hold_1);

endmodule

// File: tb/tb_onchip_ram_dual_master_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for onchip_ram_dual_master_arbiter.
// The bench contains a behavioural single-port RAM: write in place, 1-cycle
// read. A reference arbiter model predicts grants and the RAM drive for every
// cycle. Read results are pushed to a per-master expected queue when the read
// is predicted to be accepted. They are popped when the return cycle arrives.
// Compile with +define+ONCHIP_ARB_FIXED_PRIO_EN to use the fixed-priority model.
// ---------------------------------------------------------------------------
module tb_onchip_ram_dual_master_arbiter;

  localparam int ADDR_W       = 13;
  localparam int DATA_W       = 32;
  localparam int BE_W         = DATA_W / 8;
  localparam int DEPTH        = 5120;
  localparam int STARVE_LIMIT = 4;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] m0_address = '0, m1_address = '0;
  logic              m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [BE_W-1:0]   m0_byteenable = '0, m1_byteenable = '0;
  logic [DATA_W-1:0] m0_writedata = '0, m1_writedata = '0;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0] ram_address;
  logic [BE_W-1:0]   ram_byteenable;
  logic [DATA_W-1:0] ram_writedata;
  logic              ram_chipselect, ram_write, ram_clken;
  logic [DATA_W-1:0] ram_readdata = '0;

  onchip_ram_dual_master_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_writedata(ram_writedata), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
  );

  // -------------------------------------------------------------------------
  // Behavioural RAM (the DUT's environment) and reference contents
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];

  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < BE_W; b++) begin
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
        end
      end else begin
        ram_readdata <= mem[ram_address];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] exp_q0[$];
  logic [DATA_W-1:0] exp_q1[$];
  logic [DATA_W-1:0] last_rd0 = '0, last_rd1 = '0;
  logic              mdl_last_g = 1'b1;
  int                mdl_starve = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic set_m0(input logic rd, input logic wr, input int addr,
                        input logic [BE_W-1:0] be, input logic [DATA_W-1:0] wd);
    m0_read = rd; m0_write = wr; m0_address = ADDR_W'(addr);
    m0_byteenable = be; m0_writedata = wd;
  endtask

  task automatic set_m1(input logic rd, input logic wr, input int addr,
                        input logic [BE_W-1:0] be, input logic [DATA_W-1:0] wd);
    m1_read = rd; m1_write = wr; m1_address = ADDR_W'(addr);
    m1_byteenable = be; m1_writedata = wd;
  endtask

  task automatic idle();
    set_m0(1'b0, 1'b0, 0, '0, '0);
    set_m1(1'b0, 1'b0, 0, '0, '0);
  endtask

  // The inputs are already driven when this task is called. It checks all
  // outputs mid-cycle, updates the reference model for the coming edge, and
  // returns just after that edge.
  task automatic cycle();
    logic r0, r1, g0, g1, acc, wr, inr;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wd, exp_d;
    @(negedge clk);
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    g0 = 1'b0;
    g1 = 1'b0;
    if (!reset) begin
`ifdef ONCHIP_ARB_FIXED_PRIO_EN
      g1 = r1 && (!r0 || mdl_starve == STARVE_LIMIT);
      g0 = r0 && !g1;
`else
      if (r0 && r1) begin
        g0 = mdl_last_g;
        g1 = !mdl_last_g;
      end else begin
        g0 = r0;
        g1 = r1;
      end
`endif
    end
    check("m0_waitrequest", 32'(m0_waitrequest), 32'(!g0));
    check("m1_waitrequest", 32'(m1_waitrequest), 32'(!g1));
    check("ram_clken", 32'(ram_clken), 32'(!reset));

    // Read returns
    if (reset) begin
      check("m0_readdatavalid_rst", 32'(m0_readdatavalid), 0);
      check("m1_readdatavalid_rst", 32'(m1_readdatavalid), 0);
      check("m0_readdata_rst", m0_readdata, '0);
      check("m1_readdata_rst", m1_readdata, '0);
    end else begin
      check("m0_readdatavalid", 32'(m0_readdatavalid), 32'(exp_q0.size() > 0));
      check("m1_readdatavalid", 32'(m1_readdatavalid), 32'(exp_q1.size() > 0));
      if (exp_q0.size() > 0) last_rd0 = exp_q0.pop_front();
      if (exp_q1.size() > 0) last_rd1 = exp_q1.pop_front();
      check("m0_readdata", m0_readdata, last_rd0);
      check("m1_readdata", m1_readdata, last_rd1);
    end

    // RAM drive
    acc  = g0 | g1;
    addr = g1 ? m1_address : m0_address;
    be   = g1 ? m1_byteenable : m0_byteenable;
    wd   = g1 ? m1_writedata : m0_writedata;
    wr   = g1 ? m1_write : m0_write;
    inr  = int'(addr) < DEPTH;
    check("ram_chipselect", 32'(ram_chipselect), 32'(acc && inr));
    if (acc && inr) begin
      check("ram_write", 32'(ram_write), 32'(wr));
      check("ram_address", 32'(ram_address), 32'(addr));
    end else begin
      check("ram_write_idle", 32'(ram_write), 0);
    end

    // Model update for the coming edge
    if (reset) begin
      exp_q0.delete();
      exp_q1.delete();
      last_rd0 = '0;
      last_rd1 = '0;
      mdl_last_g = 1'b1;
      mdl_starve = 0;
    end else begin
      if (r1 && !g1) mdl_starve = (mdl_starve == 15) ? 15 : mdl_starve + 1;
      else mdl_starve = 0;
      if (acc) begin
        mdl_last_g = g1;
        if (wr) begin
          if (inr) begin
            for (int b = 0; b < BE_W; b++) begin
              if (be[b]) ref_mem[addr][8*b +: 8] = wd[8*b +: 8];
            end
          end
        end else begin
          exp_d = inr ? ref_mem[addr] : '0;
          if (g0) exp_q0.push_back(exp_d);
          else exp_q1.push_back(exp_d);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin : main
    int mism;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = DATA_W'(i) * 32'h9E37_79B9 ^ 32'h5A5A_0000;
      ref_mem[i] = mem[i];
    end
    mem[16] = 32'hDEAD_BEEF; ref_mem[16] = 32'hDEAD_BEEF;
    mem[5]  = 32'h0;         ref_mem[5]  = 32'h0;

    // Reset state
    idle();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;

    // Lone m0 read of 0x10
    set_m0(1'b1, 1'b0, 16, '0, '0);
    cycle();
    idle();
    cycle();
    check("t1_m0_readdata", m0_readdata, 32'hDEAD_BEEF);

    // Both masters read every cycle from reset release
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_m0(1'b1, 1'b0, $urandom_range(0, 63), '0, '0);
      set_m1(1'b1, 1'b0, $urandom_range(0, 63), '0, '0);
      cycle();
    end
    idle();
    cycle();

    // Partial write by m0, then an immediate read of the same word by m1
    set_m0(1'b0, 1'b1, 5, 4'b0011, 32'h1234_5678);
    cycle();
    set_m0(1'b0, 1'b0, 0, '0, '0);
    set_m1(1'b1, 1'b0, 5, '0, '0);
    cycle();
    idle();
    cycle();
    check("t3_m1_readdata", m1_readdata, 32'h0000_5678);

    // Reset lands on the return cycle of an m1 read
    set_m1(1'b1, 1'b0, 20, '0, '0);
    cycle();
    idle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    set_m0(1'b1, 1'b0, 21, '0, '0);
    set_m1(1'b1, 1'b0, 22, '0, '0);
    cycle();
    check("t5_first_contention_m0", 32'(m0_readdatavalid), 1);
    idle();
    cycle();

    // Out-of-range write then read
    set_m0(1'b0, 1'b1, DEPTH, 4'hF, 32'hCAFE_F00D);
    cycle();
    set_m0(1'b1, 1'b0, DEPTH, '0, '0);
    cycle();
    idle();
    cycle();
    check("t6_m0_readdata_oor", m0_readdata, '0);

`ifdef ONCHIP_ARB_FIXED_PRIO_EN
    // Continuous contention, then m1 alone
    for (int i = 0; i < 15; i++) begin
      set_m0(1'b1, 1'b0, $urandom_range(0, 63), '0, '0);
      set_m1(1'b1, 1'b0, $urandom_range(0, 63), '0, '0);
      cycle();
    end
    set_m0(1'b0, 1'b0, 0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      set_m1(1'b1, 1'b0, $urandom_range(0, 63), '0, '0);
      cycle();
    end
    idle();
    cycle();
`endif

    // Random mixed traffic, including out-of-range addresses
    for (int i = 0; i < 300; i++) begin
      int op0, op1, a0, a1;
      op0 = $urandom_range(0, 3);
      op1 = $urandom_range(0, 3);
      a0  = ($urandom_range(0, 7) == 0) ? $urandom_range(DEPTH, 8191) : $urandom_range(0, 63);
      a1  = ($urandom_range(0, 7) == 0) ? $urandom_range(DEPTH, 8191) : $urandom_range(0, 63);
      set_m0(op0[0], op0[1], a0, BE_W'($urandom_range(0, 15)), $urandom());
      set_m1(op1[0], op1[1], a1, BE_W'($urandom_range(0, 15)), $urandom());
      cycle();
    end
    idle();
    cycle();
    cycle();

    // RAM contents must match the reference
    mism = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i] !== ref_mem[i]) mism++;
    end
    check("ram_contents", 32'(mism), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
